// File: rtl/fifo_pkg.sv
// Definitions shared by the nibble FIFO, its port arbiter and the read-side word packer.
package fifo_pkg;

  localparam int DEF_BUS_WIDTH = 4;

  // Width of a counter that must reach n inclusive.
  function automatic int cnt_w(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/fifo_word_packer_nibble_shreg.sv
// Indexed-write accumulator that holds the leading entries of a word until its last entry arrives.
module nibble_shreg #(
  parameter int BUS_WIDTH = 4,
  parameter int ENTRIES   = 3,
  parameter int IDX_W     = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [BUS_WIDTH-1:0]         wr_data,
  output logic [ENTRIES*BUS_WIDTH-1:0] data
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (wr_en) begin
      for (int k = 0; k < ENTRIES; k++) begin
        if (wr_idx == IDX_W'(k)) data[k*BUS_WIDTH +: BUS_WIDTH] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/fifo_word_packer.sv
// Pops BUS_WIDTH-bit FIFO entries and packs NIBBLES of them into one word behind a valid/ready slice.
// The first popped entry lands in the least-significant bits of the output word.
module fifo_word_packer
  import fifo_pkg::*;
#(
  parameter int BUS_WIDTH = DEF_BUS_WIDTH,
  parameter int NIBBLES   = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           fifo_empty,
  input  logic [BUS_WIDTH-1:0]           fifo_dout,
  input  logic                           fifo_rd_gnt,
  output logic                           fifo_rd_req,
  output logic                           fifo_wnr,
  input  logic                           flush,
  output logic [BUS_WIDTH*NIBBLES-1:0]   out_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [cnt_w(NIBBLES)-1:0]      partial_cnt
);

  localparam int OUT_WIDTH = BUS_WIDTH * NIBBLES;
  localparam int CNT_W     = cnt_w(NIBBLES);
  localparam int SHREG_W   = (NIBBLES - 1) * BUS_WIDTH;

  logic               pend;
  logic               drop;
  logic [CNT_W:0]     occ;
  logic               slot_free;
  logic               pop_fire;
  logic               keep;
  logic               complete;
  logic [SHREG_W-1:0] shreg;

  // The last entry of a word may only be requested once the output slot is known to be free.
  always_comb begin
    occ         = {1'b0, partial_cnt} + (CNT_W + 1)'(pend);
    slot_free   = !out_valid || out_ready;
    fifo_rd_req = !rst && !fifo_empty && !flush
                  && (occ < (CNT_W + 1)'(NIBBLES))
                  && ((occ < (CNT_W + 1)'(NIBBLES - 1)) || slot_free);
    pop_fire    = fifo_rd_req && fifo_rd_gnt;
    keep        = pend && !drop && !flush;
    complete    = keep && (partial_cnt == CNT_W'(NIBBLES - 1));
  end

  assign fifo_wnr = 1'b0;

  // A flush discards the entry being captured on the same edge; drop covers any later in-flight entry.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend        <= 1'b0;
      drop        <= 1'b0;
      partial_cnt <= '0;
      out_valid   <= 1'b0;
      out_data    <= '0;
    end else begin
      pend <= pop_fire;
      if (flush) drop <= pop_fire;
      else if (pend) drop <= 1'b0;

      if (flush || complete) partial_cnt <= '0;
      else if (keep) partial_cnt <= partial_cnt + CNT_W'(1);

      if (complete) begin
        out_data  <= {fifo_dout, shreg};
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  nibble_shreg #(
    .BUS_WIDTH (BUS_WIDTH),
    .ENTRIES   (NIBBLES - 1),
    .IDX_W     (CNT_W)
  ) u_shreg (
    .clk     (clk),
    .rst     (rst),
    .clear   (flush || complete),
    .wr_en   (keep),
    .wr_idx  (partial_cnt),
    .wr_data (fifo_dout),
    .data    (shreg)
  );

endmodule

// File: tb/tb_fifo_word_packer.sv
// Scoreboard bench for fifo_word_packer: a behavioural FIFO feeds the packer, a monitor checks every
// accepted word against hand-computed expectations, directed probes cover reset, hold, flush and grant gaps.
module tb_fifo_word_packer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty;
  logic [3:0]  fifo_dout = 4'h0;
  logic        fifo_rd_gnt = 1'b1;
  logic        fifo_rd_req;
  logic        fifo_wnr;
  logic        flush = 1'b0;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  partial_cnt;

  logic [3:0]  mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  logic [15:0] exp_q [$];
  int          checks = 0;
  int          passes = 0;

  fifo_word_packer #(.BUS_WIDTH(4), .NIBBLES(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .fifo_empty  (fifo_empty),
    .fifo_dout   (fifo_dout),
    .fifo_rd_gnt (fifo_rd_gnt),
    .fifo_rd_req (fifo_rd_req),
    .fifo_wnr    (fifo_wnr),
    .flush       (flush),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .partial_cnt (partial_cnt)
  );

  always #5 clk = ~clk;

  // FIFO model: read data appears the cycle after a granted pop, empty updates after the pop edge.
  assign fifo_empty = (wr_ptr == rd_ptr);
  always @(posedge clk) begin
    if (fifo_rd_req && fifo_rd_gnt) begin
      fifo_dout <= mem[rd_ptr];
      rd_ptr    <= rd_ptr + 8'd1;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  task automatic applyStimulus(input logic [31:0] data, input int n);
    for (int i = 0; i < n; i++) begin
      mem[wr_ptr] = data[i*4 +: 4];
      wr_ptr      = wr_ptr + 8'd1;
    end
  endtask

  task automatic expectWord(input logic [15:0] word);
    exp_q.push_back(word);
  endtask

  task automatic waitDrain(input int limit, input bit toggle_gnt);
    int cyc = 0;
    while (exp_q.size() != 0 && cyc < limit) begin
      @(posedge clk);
      #2;
      if (toggle_gnt) fifo_rd_gnt = ~fifo_rd_gnt;
      cyc++;
    end
    fifo_rd_gnt = 1'b1;
    checkOutput("drain", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: a word seen valid with ready high at the falling edge is consumed on the next rising edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          $display("[TB] FAIL unexpected_word: got %0h, expected no word", out_data);
        end else begin
          checkOutput("word", 32'(out_data), 32'(exp_q.pop_front()));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_out_data", 32'(out_data), 32'd0);
    checkOutput("rst_partial_cnt", 32'(partial_cnt), 32'd0);
    checkOutput("rst_rd_req", 32'(fifo_rd_req), 32'd0);
    checkOutput("fifo_wnr", 32'(fifo_wnr), 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    // 1: four entries, continuous grant and ready
    @(posedge clk); #2;
    applyStimulus(32'h0000_4321, 4);
    expectWord(16'h4321);
    waitDrain(30, 1'b0);
    @(negedge clk);
    checkOutput("t1_valid_one_cycle", 32'(out_valid), 32'd0);

    // 2: back-pressure holds the first word and stalls the last pop of the second
    @(posedge clk); #2;
    out_ready = 1'b0;
    applyStimulus(32'h8765_4321, 8);
    expectWord(16'h4321);
    expectWord(16'h8765);
    repeat (15) @(posedge clk);
    @(negedge clk);
    checkOutput("t2_held_valid", 32'(out_valid), 32'd1);
    checkOutput("t2_held_data", 32'(out_data), 32'h4321);
    checkOutput("t2_partial_cnt", 32'(partial_cnt), 32'd3);
    checkOutput("t2_req_stalled", 32'(fifo_rd_req), 32'd0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    waitDrain(40, 1'b0);

    // 3: FIFO runs dry mid-word
    @(posedge clk); #2;
    applyStimulus(32'h0000_0021, 2);
    repeat (10) @(posedge clk);
    @(negedge clk);
    checkOutput("t3_partial_cnt", 32'(partial_cnt), 32'd2);
    checkOutput("t3_req_empty", 32'(fifo_rd_req), 32'd0);
    checkOutput("t3_no_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    applyStimulus(32'h0000_0043, 2);
    expectWord(16'h4321);
    waitDrain(30, 1'b0);

    // 4: flush on the edge that captures the third entry
    @(posedge clk); #2;
    applyStimulus(32'h0000_0CBA, 3);
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("t4_pre_flush_cnt", 32'(partial_cnt), 32'd2);
    flush = 1'b1;
    @(posedge clk); #2;
    flush = 1'b0;
    @(negedge clk);
    checkOutput("t4_flush_cnt", 32'(partial_cnt), 32'd0);
    checkOutput("t4_flush_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #2;
    applyStimulus(32'h0000_4321, 4);
    expectWord(16'h4321);
    waitDrain(30, 1'b0);

    // 5: grant alternating every cycle
    @(posedge clk); #2;
    applyStimulus(32'h8765_4321, 8);
    expectWord(16'h4321);
    expectWord(16'h8765);
    waitDrain(80, 1'b1);

    // 6: reset with a partial word and a held output word
    @(posedge clk); #2;
    out_ready = 1'b0;
    applyStimulus(32'h0765_4321, 7);
    repeat (20) @(posedge clk);
    @(negedge clk);
    checkOutput("t6_pre_cnt", 32'(partial_cnt), 32'd3);
    checkOutput("t6_pre_valid", 32'(out_valid), 32'd1);
    @(posedge clk); #2;
    applyStimulus(32'h0000_0008, 1);
    rst = 1'b1;
    #1;
    checkOutput("t6_rst_valid", 32'(out_valid), 32'd0);
    checkOutput("t6_rst_data", 32'(out_data), 32'd0);
    checkOutput("t6_rst_cnt", 32'(partial_cnt), 32'd0);
    checkOutput("t6_rst_req", 32'(fifo_rd_req), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput("t6_rst_req_held", 32'(fifo_rd_req), 32'd0);
    @(posedge clk); #2;
    out_ready = 1'b1;
    rst = 1'b0;
    applyStimulus(32'h0000_0321, 3);
    expectWord(16'h3218);
    waitDrain(30, 1'b0);

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
